regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath; successor to the single-port combinational register file.
- Clocked writes, N combinational read ports with optional write-through bypass, M write ports with fixed priority, hardwired zero register.
- Per-register busy scoreboard lets decode detect pending long-latency writebacks.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (power of 2, >=2)
- ADDR_W, $clog2(NUM_REGS), register index width (derived, not overridden)
- NUM_RD, 2, number of read ports (>=1)
- NUM_WR, 1, number of write ports (>=1)
- BYPASS, 1, 1 = read ports return the same-cycle write data; 0 = read ports return stored value only
- ZERO_R0, 1, 1 = register 0 reads as 0, ignores writes and never becomes busy

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD x ADDR_W  read port addresses
- rd_data  out  NUM_RD x DATA_W  read data, combinational
- rd_busy  out  NUM_RD  scoreboard busy bit of rd_addr[i], combinational
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR x ADDR_W  write addresses
- wr_data  in  NUM_WR x DATA_W  write data
- sb_set_en  in  1  mark sb_set_addr busy (issue of long-latency op)
- sb_set_addr  in  ADDR_W  register to mark busy
- any_busy  out  1  OR of all busy bits (drain/flush check)

Behaviour:
- Reset: rst_n low asynchronously clears all registers to 0 and all busy bits to 0. While rst_n is low, rd_data = 0, rd_busy = 0 and any_busy = 0. Writes and sets are ignored while reset is asserted.
- Write: on posedge clk, each port j with wr_en[j]=1 stores wr_data[j] into reg[wr_addr[j]]. One-cycle write latency to storage.
- Write conflict: several enabled ports with the same address in one cycle -> the highest port index wins, both in storage and in the bypass path.
- Read: rd_data[i] = reg[rd_addr[i]] combinationally, with zero added latency.
- Bypass (BYPASS=1): if any enabled write port targets rd_addr[i] in the current cycle, rd_data[i] returns that port's wr_data, applying the same priority rule. BYPASS=0 returns the pre-edge value.
- Zero register (ZERO_R0=1):
  - Reads of address 0 return 0, even when bypass is active.
  - Writes to address 0 are discarded.
  - sb_set_en to address 0 is ignored.
- Scoreboard:
  - busy[a] is set on posedge when sb_set_en and sb_set_addr=a.
  - busy[a] is cleared on posedge when any wr_en[j] targets a.
  - Simultaneous set and clear on the same address: set wins, so busy stays 1 (a new producer has been issued).
  - Set on an already-busy register leaves it busy; there is no counting, and only one outstanding producer per register is supported.
  - Write to a non-busy register leaves busy at 0.
- rd_busy[i] = busy[rd_addr[i]], with no bypass of the same-cycle set or clear. A same-cycle clear still reads busy=1, so decode stalls one extra cycle; the data itself is bypassed. This is intentional and keeps the stall path short.
- Address range: addresses >= NUM_REGS cannot occur, because NUM_REGS is a power of 2.
- Reset mid-operation: async clear takes effect immediately; the first edge after deassertion behaves as normal operation.

Decomposition:
- Shared package mips_pkg holds: DATA_W/NUM_REGS defaults, the reg_addr_t and word_t typedefs, and the REG_ZERO constant.
- One sub-module, regfile_scoreboard, holds the busy vector, set/clear priority and any_busy.
- Storage, write priority and bypass muxing stay in regfile_mp.

Test Plan:
- Reset: drive rst_n=0 mid-run after writing reg5=0xDEADBEEF -> rd_data for address 5 reads 0 immediately, without waiting for a clock edge; any_busy=0.
- Write then read: write reg3=0x12345678 at edge k -> rd_addr=3 reads 0x12345678 after edge k. With BYPASS=1 it also reads 0x12345678 during cycle k. With BYPASS=0 it reads the old value during cycle k.
- Write conflict (NUM_WR=2): port0 writes reg7=0x1, port1 writes reg7=0x2 in the same cycle -> bypass shows 0x2 and storage holds 0x2.
- Zero register: write reg0=0xFFFFFFFF and sb_set reg0 -> reg0 reads 0 and rd_busy=0 on every port.
- Scoreboard:
  - sb_set reg9 -> rd_busy=1 and any_busy=1.
  - Writeback reg9=0xAA -> busy clears at that edge.
  - Simultaneous sb_set reg9 and write reg9 -> data 0xAA is stored and busy remains 1.
- Multi-port reads (NUM_RD=3): read addresses 1, 2 and 1 while writing reg2 -> each port independently returns the correct stored or bypassed value.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths, types and register constants
package mips_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_NUM_REGS = 32;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
   typedef logic [DEF_DATA_W-1:0] word_t;

   localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file read/write/scoreboard bus
interface regfile_mp_if
   import mips_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1
);
   localparam int ADDR_W = $clog2(NUM_REGS);

   logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]             rd_busy;
   logic [NUM_WR-1:0]             wr_en;
   logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
   logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
   logic                          sb_set_en;
   logic [ADDR_W-1:0]             sb_set_addr;
   logic                          any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      input  rd_data, rd_busy, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
      output rd_data, rd_busy, any_busy
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for pending writebacks
module regfile_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_R0  = 1,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_WR-1:0]             wr_en,
   input  logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr,
   input  logic                          sb_set_en,
   input  logic [ADDR_W-1:0]             sb_set_addr,
   input  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]             rd_busy,
   output logic                          any_busy
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   // Clears first, then the set: a freshly issued producer outranks a retiring one.
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NUM_WR; j++) begin
         if (wr_en[j]) busy_nxt[wr_addr[j]] = 1'b0;
      end
      if (sb_set_en) busy_nxt[sb_set_addr] = 1'b1;
      if (ZERO_R0 != 0) busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   // Registered value only, so a same-cycle clear still stalls decode one cycle.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) rd_busy[i] = busy[rd_addr[i]];
   end

   assign any_busy = |busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, zero reg and scoreboard
module regfile_mp
   import mips_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_R0  = 1
) (
   input logic       clk,
   input logic       rst_n,
   regfile_mp_if.slave bus
);

   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

   logic [DATA_W-1:0]             regs [NUM_REGS];
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data_c;

   // Ascending port order: the last non-blocking assignment, highest port, wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && !((ZERO_R0 != 0) && bus.wr_addr[j] == ZERO_ADDR))
               regs[bus.wr_addr[j]] <= bus.wr_data[j];
         end
      end
   end

   // Reset gating also hides bypassed write data while rst_n is low.
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_data_c[i] = regs[bus.rd_addr[i]];
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i])
                  rd_data_c[i] = bus.wr_data[j];
            end
         end
         if (((ZERO_R0 != 0) && bus.rd_addr[i] == ZERO_ADDR) || !rst_n)
            rd_data_c[i] = '0;
      end
   end

   assign bus.rd_data = rd_data_c;

   regfile_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .NUM_RD   (NUM_RD),
      .NUM_WR   (NUM_WR),
      .ZERO_R0  (ZERO_R0),
      .ADDR_W   (ADDR_W)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (bus.wr_en),
      .wr_addr     (bus.wr_addr),
      .sb_set_en   (bus.sb_set_en),
      .sb_set_addr (bus.sb_set_addr),
      .rd_addr     (bus.rd_addr),
      .rd_busy     (bus.rd_busy),
      .any_busy    (bus.any_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against a reference model
module tb_regfile_mp;
   import mips_pkg::*;

   localparam int NUM_REGS = 32;
   localparam int NUM_RD   = 3;
   localparam int NUM_WR   = 2;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   word_t m_regs [NUM_REGS];
   bit    m_busy [NUM_REGS];

   regfile_mp_if #(.DATA_W(32), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();
   regfile_mp_if #(.DATA_W(32), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus_nb ();

   assign bus_nb.rd_addr     = bus.rd_addr;
   assign bus_nb.wr_en       = bus.wr_en;
   assign bus_nb.wr_addr     = bus.wr_addr;
   assign bus_nb.wr_data     = bus.wr_data;
   assign bus_nb.sb_set_en   = bus.sb_set_en;
   assign bus_nb.sb_set_addr = bus.sb_set_addr;

   regfile_mp #(.DATA_W(32), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                .BYPASS(1), .ZERO_R0(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   regfile_mp #(.DATA_W(32), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
                .BYPASS(0), .ZERO_R0(1)) dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic word_t exp_rd(input int a, input bit byp);
      if (!rst_n || a == 0) return '0;
      if (byp) begin
         for (int j = NUM_WR - 1; j >= 0; j--)
            if (bus.wr_en[j] && int'(bus.wr_addr[j]) == a) return bus.wr_data[j];
      end
      return m_regs[a];
   endfunction

   function automatic bit exp_any();
      for (int r = 0; r < NUM_REGS; r++) if (m_busy[r]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_reset();
      for (int r = 0; r < NUM_REGS; r++) begin
         m_regs[r] = '0;
         m_busy[r] = 1'b0;
      end
   endfunction

   function automatic void model_commit();
      if (!rst_n) return;
      for (int j = 0; j < NUM_WR; j++) begin
         if (bus.wr_en[j] && bus.wr_addr[j] != 0) m_regs[bus.wr_addr[j]] = bus.wr_data[j];
         if (bus.wr_en[j]) m_busy[bus.wr_addr[j]] = 1'b0;
      end
      if (bus.sb_set_en && bus.sb_set_addr != 0) m_busy[bus.sb_set_addr] = 1'b1;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic idle();
      bus.wr_en     = '0;
      bus.sb_set_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      bus.rd_addr = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.sb_set_addr = '0;
      model_reset();
      #1;
      for (int i = 0; i < NUM_RD; i++) begin
         n_checks++;
         if (bus.rd_data[i] !== 32'h0 || bus.rd_busy[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init port%0d: data %h busy %b, wanted 0/0", i, bus.rd_data[i], bus.rd_busy[i]);
         end
      end
      n_checks++;
      if (bus.any_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_init_any: got %b wanted 0", bus.any_busy);
      end
      @(negedge clk); rst_n = 1'b1;
      tick();
      // mid-run reset with live data and a busy register
      bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd5; bus.wr_data[0] = 32'hDEADBEEF;
      bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
      tick();
      idle();
      bus.rd_addr[0] = 5'd5;
      #1;
      n_checks++;
      if (bus.rd_data[0] !== 32'hDEADBEEF || bus.any_busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre: data %h any %b wanted deadbeef/1", bus.rd_data[0], bus.any_busy);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (bus.rd_data[0] !== 32'h0 || bus_nb.rd_data[0] !== 32'h0 || bus.any_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: data %h/%h any %b wanted 0/0/0", bus.rd_data[0], bus_nb.rd_data[0], bus.any_busy);
      end
      bus.wr_en[0] = 1'b1; bus.wr_data[0] = 32'h55;
      #1;
      n_checks++;
      if (bus.rd_data[0] !== 32'h0) begin
         n_fail++; $display("FAIL reset_bypass_gated: got %h wanted 0", bus.rd_data[0]);
      end
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      n_checks++;
      if (bus.rd_data[0] !== 32'h0) begin
         n_fail++; $display("FAIL reset_write_ignored: got %h wanted 0", bus.rd_data[0]);
      end
   endtask

   task automatic test_write_read();
      word_t old;
      idle();
      old = m_regs[3];
      bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd3; bus.wr_data[0] = 32'h12345678;
      bus.rd_addr[0] = 5'd3;
      #2;
      n_checks++;
      if (bus.rd_data[0] !== 32'h12345678) begin
         n_fail++; $display("FAIL wr_bypass: got %h wanted 12345678", bus.rd_data[0]);
      end
      n_checks++;
      if (bus_nb.rd_data[0] !== old) begin
         n_fail++; $display("FAIL wr_nobypass_old: got %h wanted %h", bus_nb.rd_data[0], old);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.rd_data[0] !== 32'h12345678 || bus_nb.rd_data[0] !== 32'h12345678) begin
         n_fail++; $display("FAIL wr_stored: got %h/%h wanted 12345678", bus.rd_data[0], bus_nb.rd_data[0]);
      end
   endtask

   task automatic test_conflict();
      idle();
      bus.wr_en = 2'b11;
      bus.wr_addr[0] = 5'd7; bus.wr_data[0] = 32'h1;
      bus.wr_addr[1] = 5'd7; bus.wr_data[1] = 32'h2;
      for (int i = 0; i < NUM_RD; i++) bus.rd_addr[i] = 5'd7;
      #2;
      n_checks++;
      if (bus.rd_data[1] !== 32'h2) begin
         n_fail++; $display("FAIL conflict_bypass: got %h wanted 2", bus.rd_data[1]);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.rd_data[2] !== 32'h2 || bus_nb.rd_data[0] !== 32'h2) begin
         n_fail++; $display("FAIL conflict_stored: got %h/%h wanted 2", bus.rd_data[2], bus_nb.rd_data[0]);
      end
   endtask

   task automatic test_zero();
      idle();
      bus.wr_en = 2'b11;
      bus.wr_addr[0] = 5'd0; bus.wr_data[0] = 32'hFFFFFFFF;
      bus.wr_addr[1] = 5'd0; bus.wr_data[1] = 32'hFFFFFFFF;
      bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd0;
      for (int i = 0; i < NUM_RD; i++) bus.rd_addr[i] = 5'd0;
      #2;
      for (int i = 0; i < NUM_RD; i++) begin
         n_checks++;
         if (bus.rd_data[i] !== 32'h0) begin
            n_fail++; $display("FAIL zero_bypass port%0d: got %h wanted 0", i, bus.rd_data[i]);
         end
      end
      tick();
      idle();
      #1;
      for (int i = 0; i < NUM_RD; i++) begin
         n_checks++;
         if (bus.rd_data[i] !== 32'h0 || bus_nb.rd_data[i] !== 32'h0 || bus.rd_busy[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after port%0d: data %h/%h busy %b wanted 0", i, bus.rd_data[i], bus_nb.rd_data[i], bus.rd_busy[i]);
         end
      end
      n_checks++;
      if (bus.any_busy !== exp_any()) begin
         n_fail++; $display("FAIL zero_any: got %b wanted %b", bus.any_busy, exp_any());
      end
   endtask

   task automatic test_scoreboard();
      idle();
      bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
      bus.rd_addr[0] = 5'd9;
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.rd_busy[0] !== 1'b1 || bus.any_busy !== 1'b1) begin
         n_fail++; $display("FAIL sb_set: busy %b any %b wanted 1/1", bus.rd_busy[0], bus.any_busy);
      end
      bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'hAA;
      #1;
      n_checks++;
      if (bus.rd_busy[0] !== 1'b1 || bus.rd_data[0] !== 32'hAA) begin
         n_fail++; $display("FAIL sb_clear_same_cycle: busy %b data %h wanted 1/aa", bus.rd_busy[0], bus.rd_data[0]);
      end
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.rd_busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL sb_cleared: got %b wanted 0", bus.rd_busy[0]);
      end
      bus.wr_en[0] = 1'b1; bus.wr_addr[0] = 5'd9; bus.wr_data[0] = 32'hAA;
      bus.sb_set_en = 1'b1; bus.sb_set_addr = 5'd9;
      tick();
      idle();
      #1;
      n_checks++;
      if (bus.rd_busy[0] !== 1'b1 || bus_nb.rd_data[0] !== 32'hAA) begin
         n_fail++; $display("FAIL sb_set_wins: busy %b data %h wanted 1/aa", bus.rd_busy[0], bus_nb.rd_data[0]);
      end
      bus.wr_en[0] = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_multi_read();
      word_t old2;
      idle();
      old2 = m_regs[2];
      bus.rd_addr[0] = 5'd1; bus.rd_addr[1] = 5'd2; bus.rd_addr[2] = 5'd1;
      bus.wr_en[1] = 1'b1; bus.wr_addr[1] = 5'd2; bus.wr_data[1] = 32'hC0FFEE02;
      #2;
      for (int i = 0; i < NUM_RD; i++) begin
         n_checks++;
         if (bus.rd_data[i] !== exp_rd(bus.rd_addr[i], 1'b1)) begin
            n_fail++; $display("FAIL multi_rd port%0d: got %h wanted %h", i, bus.rd_data[i], exp_rd(bus.rd_addr[i], 1'b1));
         end
      end
      n_checks++;
      if (bus.rd_data[1] !== 32'hC0FFEE02 || bus_nb.rd_data[1] !== old2) begin
         n_fail++; $display("FAIL multi_rd_port1: got %h/%h wanted c0ffee02/%h", bus.rd_data[1], bus_nb.rd_data[1], old2);
      end
      tick();
      idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         for (int j = 0; j < NUM_WR; j++) begin
            bus.wr_en[j]   = 1'($urandom_range(0, 1));
            bus.wr_addr[j] = 5'($urandom_range(0, 7));
            bus.wr_data[j] = $urandom;
         end
         bus.sb_set_en   = 1'($urandom_range(0, 1));
         bus.sb_set_addr = 5'($urandom_range(0, 7));
         for (int i = 0; i < NUM_RD; i++)
            bus.rd_addr[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         #2;
         for (int i = 0; i < NUM_RD; i++) begin
            n_checks++;
            if (bus.rd_data[i] !== exp_rd(bus.rd_addr[i], 1'b1) ||
                bus_nb.rd_data[i] !== exp_rd(bus.rd_addr[i], 1'b0) ||
                bus.rd_busy[i] !== m_busy[bus.rd_addr[i]] ||
                bus_nb.rd_busy[i] !== m_busy[bus.rd_addr[i]]) begin
               n_fail++;
               $display("FAIL random c%0d port%0d a%0d: data %h/%h busy %b wanted %h/%h %b", c, i,
                        bus.rd_addr[i], bus.rd_data[i], bus_nb.rd_data[i], bus.rd_busy[i],
                        exp_rd(bus.rd_addr[i], 1'b1), exp_rd(bus.rd_addr[i], 1'b0), m_busy[bus.rd_addr[i]]);
            end
         end
         n_checks++;
         if (bus.any_busy !== exp_any()) begin
            n_fail++; $display("FAIL random_any c%0d: got %b wanted %b", c, bus.any_busy, exp_any());
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_conflict();
      test_zero();
      test_scoreboard();
      test_multi_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
